bus_xfer_ctrl: RTL

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_pkg.sv | 21 ++
 rtl/bus_xfer_fifo.sv | 45 ++++
 rtl/bus_xfer_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer controller.
package bus_xfer_pkg;

  localparam int unsigned DefNreg  = 4;
  localparam int unsigned DefW     = 16;
  localparam int unsigned DefDepth = 4;

  // Controller phases; a transfer walks Drive -> Write -> Done.
  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StWrite,
    StDone
  } xfer_state_e;

  // Width of a register index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_xfer_fifo.sv
// Command queue: show-ahead FIFO, DEPTH a power of two (>= 2).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bus_xfer_fifo #(
  parameter int unsigned EW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  // Pointer update; a push and a pop in the same cycle both take effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry storage needs no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer controller over a shared tri-state bus.
// Commands are queued, then each one drives the source onto the bus for
// two cycles and loads the destination on the second.
// Optional feature: define BUS_XFER_SNOOP_EN to add snoop_data/snoop_valid.
module bus_xfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter int unsigned NREG  = DefNreg,
  parameter int unsigned W     = DefW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [idx_width(NREG)-1:0] cmd_src,
  input  logic [idx_width(NREG)-1:0] cmd_dst,
  output logic [NREG-1:0]            reg_read,
  output logic [NREG-1:0]            reg_write,
  input  logic [W-1:0]               bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
`ifdef BUS_XFER_SNOOP_EN
  ,
  output logic [W-1:0]               snoop_data,
  output logic                       snoop_valid
`endif
);

  localparam int unsigned IW = idx_width(NREG);
  localparam int unsigned EW = 2 * IW;

  xfer_state_e     state_q, state_d;
  logic [IW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [NREG-1:0] read_q, read_d, write_q, write_d;
  logic            done_q, done_d, err_q, err_d;

  logic [EW-1:0]   head;
  logic [IW-1:0]   head_src, head_dst;
  logic            head_rej;
  logic            pop, full, empty;

  bus_xfer_fifo #(
    .EW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .pop   (pop),
    .wdata ({cmd_dst, cmd_src}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign head_src = head[IW-1:0];
  assign head_dst = head[EW-1:IW];
  // Out-of-range indices are rejected exactly like a self-transfer.
  assign head_rej = (head_src == head_dst) || (32'(head_src) >= NREG) || (32'(head_dst) >= NREG);

  assign cmd_ready = !full;
  assign busy      = (state_q != StIdle) || !empty;
  assign reg_read  = read_q;
  assign reg_write = write_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    pop     = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (!empty) begin
          pop     = 1'b1;
          src_d   = head_src;
          dst_d   = head_dst;
          err_d   = head_rej;
          state_d = head_rej ? StDone : StDrive;
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: state_d = StWrite;
      StWrite: state_d = StDone;
      default: state_d = StIdle;
    endcase
    done_d  = (state_d == StDone);
    read_d  = ((state_d == StDrive) || (state_d == StWrite)) ? (NREG'(1) << src_d) : '0;
    write_d = (state_d == StWrite) ? (NREG'(1) << dst_d) : '0;
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      read_q  <= '0;
      write_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      read_q  <= read_d;
      write_q <= write_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_XFER_SNOOP_EN
  logic [W-1:0] snoop_data_q;
  logic         snoop_valid_q;

  // Capture the bus as the destination loads; flag it in the Done cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snoop_data_q  <= '0;
      snoop_valid_q <= 1'b0;
    end else begin
      if (state_q == StWrite) snoop_data_q <= bus;
      snoop_valid_q <= (state_q == StWrite);
    end
  end

  assign snoop_data  = snoop_data_q;
  assign snoop_valid = snoop_valid_q;
`else
  // The bus is only observed by the snoop capture.
  logic unused_bus;
  assign unused_bus = ^bus;
`endif

endmodule
